// File: rtl/gate_pkg.sv
// Shared types, constants and the gate-bank truth table for the gate self-test sequencer.
package gate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } gate_state_e;

  localparam int unsigned VEC_COUNT = 4;

  // Bit order matches gate_final: {~A, A^B, A|B, A&B}.
  function automatic logic [3:0] gate_expected(input logic a, input logic b);
    return {~a, a ^ b, a | b, a & b};
  endfunction

endpackage

// File: rtl/gate_final.sv
// Two-input gate bank under test: AND, OR, XOR and NOT of A.
module gate_final (
  input  logic       A,
  input  logic       B,
  output logic [3:0] Y
);

  assign Y = {~A, A ^ B, A | B, A & B};

endmodule

// File: rtl/gate_selftest_top.sv
// Thin wrapper closing the loop between the self-test sequencer and the gate bank.
module gate_selftest_top #(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [1:0] vec_idx,
  output logic [3:0] err_vec,
  output logic [2:0] err_cnt
);

  logic       a_drv;
  logic       b_drv;
  logic [3:0] y;

  gate_selftest_ctrl #(.HOLD_CYCLES(HOLD_CYCLES)) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .y_in    (y),
    .a_drv   (a_drv),
    .b_drv   (b_drv),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .vec_idx (vec_idx),
    .err_vec (err_vec),
    .err_cnt (err_cnt)
  );

  gate_final u_bank (
    .A (a_drv),
    .B (b_drv),
    .Y (y)
  );

endmodule

// File: rtl/gate_selftest_ctrl.sv
// Sweeps the four {A,B} combinations through the gate bank, holds each for a
// settle window, then checks the bank result and accumulates an error summary.
module gate_selftest_ctrl
  import gate_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] y_in,
  output logic       a_drv,
  output logic       b_drv,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [1:0] vec_idx,
  output logic [3:0] err_vec,
  output logic [2:0] err_cnt
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_DRIVE = ST_DRIVE;
  localparam logic [1:0] S_CHECK = ST_CHECK;
  localparam logic [1:0] S_DONE  = ST_DONE;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [1:0] VEC_LAST  = 2'(VEC_COUNT - 1);
  localparam logic [2:0] CNT_MAX   = 3'(VEC_COUNT);

  logic [1:0] state;
  logic [7:0] hold_cnt;
  logic [3:0] expected;
  logic       vec_bad;
  logic [2:0] err_cnt_nxt;
  logic [1:0] vec_nxt;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    expected    = gate_expected(a_drv, b_drv);
    vec_bad     = 1'b1;
    // NOTE: compare for equality and default to "bad" so an X on y_in lands
    // in the error path instead of silently falling through as a match.
    if (y_in == expected) vec_bad = 1'b0;
    err_cnt_nxt = (vec_bad && (err_cnt != CNT_MAX)) ? err_cnt + 3'd1 : err_cnt;
    vec_nxt     = vec_idx + 2'd1;
  end

  // NOTE: all state uses non-blocking assignments; reset is synchronous, so
  // it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
      a_drv    <= 1'b0;
      b_drv    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      vec_idx  <= '0;
      err_vec  <= '0;
      err_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state    <= S_DRIVE;
            busy     <= 1'b1;
            hold_cnt <= '0;
            vec_idx  <= '0;
            a_drv    <= 1'b0;
            b_drv    <= 1'b0;
            err_vec  <= '0;
            err_cnt  <= '0;
            pass     <= 1'b0;
          end
        end

        S_DRIVE: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            pass  <= 1'b0;
            a_drv <= 1'b0;
            b_drv <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
            if (hold_cnt == HOLD_LAST) state <= S_CHECK;
          end
        end

        S_CHECK: begin
          // The result is recorded even when abort lands in this same cycle.
          if (vec_bad) err_vec[vec_idx] <= 1'b1;
          err_cnt <= err_cnt_nxt;
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            pass  <= 1'b0;
            a_drv <= 1'b0;
            b_drv <= 1'b0;
          end else if (vec_idx == VEC_LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt_nxt == 3'd0);
            a_drv <= 1'b0;
            b_drv <= 1'b0;
          end else begin
            state    <= S_DRIVE;
            hold_cnt <= '0;
            vec_idx  <= vec_nxt;
            a_drv    <= vec_nxt[1];
            b_drv    <= vec_nxt[0];
          end
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// Directed bench for gate_selftest_ctrl: good bank, single-bit fault, stuck bank,
// abort, restart filtering, mid-sweep reset and alternate hold lengths.
module tb_gate_selftest_ctrl;
  import gate_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] y_in;
  logic       a, b, busy, done, pass;
  logic [1:0] vec_idx;
  logic [3:0] err_vec;
  logic [2:0] err_cnt;

  logic       start_h1 = 1'b0, start_h5 = 1'b0;
  logic [3:0] y_h1, y_h5;
  logic       a_h1, b_h1, busy_h1, done_h1, pass_h1;
  logic       a_h5, b_h5, busy_h5, done_h5, pass_h5;
  logic [1:0] vi_h1, vi_h5;
  logic [3:0] ev_h1, ev_h5;
  logic [2:0] ec_h1, ec_h5;

  int n_cmp = 0;
  int n_mis = 0;

  // Bank model: 0 = correct, 1 = bit 2 flipped for {A,B}=10, 2 = stuck at zero.
  always_comb begin
    y_in = gate_expected(a, b);
    case (mode)
      2'd1: if ({a, b} == 2'b10) y_in[2] = ~y_in[2];
      2'd2: y_in = 4'b0000;
      default: ;
    endcase
  end
  assign y_h1 = gate_expected(a_h1, b_h1);
  assign y_h5 = gate_expected(a_h5, b_h5);

  gate_selftest_ctrl #(.HOLD_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .y_in(y_in),
    .a_drv(a), .b_drv(b), .busy(busy), .done(done), .pass(pass),
    .vec_idx(vec_idx), .err_vec(err_vec), .err_cnt(err_cnt)
  );

  gate_selftest_ctrl #(.HOLD_CYCLES(1)) dut_h1 (
    .clk(clk), .rst(rst), .start(start_h1), .abort(1'b0), .y_in(y_h1),
    .a_drv(a_h1), .b_drv(b_h1), .busy(busy_h1), .done(done_h1), .pass(pass_h1),
    .vec_idx(vi_h1), .err_vec(ev_h1), .err_cnt(ec_h1)
  );

  gate_selftest_ctrl #(.HOLD_CYCLES(5)) dut_h5 (
    .clk(clk), .rst(rst), .start(start_h5), .abort(1'b0), .y_in(y_h5),
    .a_drv(a_h5), .b_drv(b_h5), .busy(busy_h5), .done(done_h5), .pass(pass_h5),
    .vec_idx(vi_h5), .err_vec(ev_h5), .err_cnt(ec_h5)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full HOLD_CYCLES=2 sweep; start is re-pulsed while busy and in DONE to
  // confirm both are ignored. Returns at the cycle after DONE (IDLE).
  task automatic sweep(input logic [3:0] exp_vec, input logic [2:0] exp_cnt, input string tag);
    logic [1:0] v;
    logic       exp_pass;
    exp_pass = (exp_cnt == 3'd0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check({tag, " cleared"}, {busy, pass, err_vec, err_cnt}, {1'b1, 1'b0, 4'b0000, 3'd0});
    for (int c = 1; c <= 12; c++) begin
      v = 2'((c - 1) / 3);
      check($sformatf("%s drive c%0d", tag, c), {busy, done, a, b, vec_idx}, {1'b1, 1'b0, v, v});
      if (c == 5) start = 1'b1;
      step(1);
      start = 1'b0;
    end
    check({tag, " done"}, {busy, done, pass, err_vec, err_cnt},
          {1'b0, 1'b1, exp_pass, exp_vec, exp_cnt});
    start = 1'b1;
    step(1);
    start = 1'b0;
    check({tag, " after"}, {busy, done, pass, a, b, err_vec, err_cnt},
          {1'b0, 1'b0, exp_pass, 1'b0, 1'b0, exp_vec, exp_cnt});
  endtask

  initial begin
    int n;
    logic saw;

    // Reset state, held and released.
    step(3);
    check("reset", {a, b, busy, done, pass, vec_idx, err_vec, err_cnt}, 16'h0000);
    rst = 1'b0;
    step(1);
    check("idle", {a, b, busy, done, pass, vec_idx, err_vec, err_cnt}, 16'h0000);

    // Back-to-back sweeps: each new start lands in the cycle after DONE.
    sweep(4'b0000, 3'd0, "good");
    mode = 2'd1;
    sweep(4'b0100, 3'd1, "bit2");
    mode = 2'd2;
    sweep(4'b1111, 3'd4, "stuck");

    // Abort during vector 2 DRIVE keeps partial results, no done pulse.
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(6);
    check("abort at v2", {busy, a, b, vec_idx}, {1'b1, 1'b1, 1'b0, 2'd2});
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abort drive", {busy, done, pass, a, b, err_vec, err_cnt},
          {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, 3'd2});
    saw = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (done || busy) saw = 1'b1;
      step(1);
    end
    check("abort quiet", {15'd0, saw}, 16'd0);
    mode = 2'd0;
    sweep(4'b0000, 3'd0, "post abort");

    // Abort coinciding with a mismatching CHECK still records the mismatch.
    mode = 2'd2;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abort check", {busy, done, pass, err_vec, err_cnt},
          {1'b0, 1'b0, 1'b0, 4'b0001, 3'd1});

    // start together with abort in IDLE: nothing happens.
    start = 1'b1;
    abort = 1'b1;
    step(1);
    start = 1'b0;
    abort = 1'b0;
    check("start+abort", {busy, done, pass, a, b, vec_idx, err_vec, err_cnt},
          {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 3'd1});
    step(2);
    check("start+abort idle", {busy, done}, 2'b00);

    // Reset mid-sweep clears everything at the next edge.
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(5);
    check("pre reset", {busy, vec_idx, err_vec, err_cnt}, {1'b1, 2'd1, 4'b0001, 3'd1});
    rst = 1'b1;
    step(1);
    check("mid reset", {a, b, busy, done, pass, vec_idx, err_vec, err_cnt}, 16'h0000);
    rst = 1'b0;
    step(2);
    check("post reset", {busy, done}, 2'b00);

    // Alternate hold lengths: done latency is 4*(H+1)+1 cycles after start.
    start_h1 = 1'b1;
    step(1);
    start_h1 = 1'b0;
    n = 1;
    while (!done_h1 && n < 60) begin
      step(1);
      n++;
    end
    check("h1 latency", 16'(n), 16'd9);
    check("h1 pass", {pass_h1, ev_h1, ec_h1}, {1'b1, 4'b0000, 3'd0});

    start_h5 = 1'b1;
    step(1);
    start_h5 = 1'b0;
    n = 1;
    while (!done_h5 && n < 60) begin
      step(1);
      n++;
    end
    check("h5 latency", 16'(n), 16'd25);
    check("h5 pass", {pass_h5, ev_h5, ec_h5}, {1'b1, 4'b0000, 3'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
